// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial pair-wise magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam int PAIR_W = 2;

endpackage

// File: rtl/serial_cmp_if.sv
// Start/operand/result bundle between a requester and serial_cmp.
interface serial_cmp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             agtb;
  logic             aeqb;
  logic             altb;

  modport master (
    output start, a, b,
    input  busy, done, agtb, aeqb, altb
  );

  modport slave (
    input  start, a, b,
    output busy, done, agtb, aeqb, altb
  );
endinterface

// File: rtl/serial_cmp_cmp2_slice.sv
// Combinational compare of one 2-bit operand pair.
module cmp2_slice
  import serial_cmp_pkg::*;
(
  input  logic [PAIR_W-1:0] a,
  input  logic [PAIR_W-1:0] b,
  output logic              gt,
  output logic              lt
);
  assign gt = (a > b);
  assign lt = (a < b);
endmodule

// File: rtl/serial_cmp.sv
// Serial magnitude comparator, one 2-bit pair per cycle, MSB first.
// Define SERIAL_CMP_SIGNED_EN for two's-complement operands.
module serial_cmp
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_cmp_if.slave  bus
);
  localparam int NPAIR = WIDTH / PAIR_W;
  localparam int CNT_W = $clog2(NPAIR + 1);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("serial_cmp: WIDTH must be even and >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             agtb_q, agtb_d;
  logic             aeqb_q, aeqb_d;
  logic             altb_q, altb_d;
  logic [WIDTH-1:0] a_cap, b_cap;
  logic             p_gt, p_lt;

`ifdef SERIAL_CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement onto unsigned order.
  assign a_cap = {~bus.a[WIDTH-1], bus.a[WIDTH-2:0]};
  assign b_cap = {~bus.b[WIDTH-1], bus.b[WIDTH-2:0]};
`else
  assign a_cap = bus.a;
  assign b_cap = bus.b;
`endif

  cmp2_slice u_slice (
    .a  (a_sh_q[WIDTH-1 -: PAIR_W]),
    .b  (b_sh_q[WIDTH-1 -: PAIR_W]),
    .gt (p_gt),
    .lt (p_lt)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    agtb_d  = agtb_q;
    aeqb_d  = aeqb_q;
    altb_d  = altb_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          a_sh_d  = a_cap;
          b_sh_d  = b_cap;
          cnt_d   = CNT_W'(NPAIR);
          dec_d   = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q << PAIR_W;
        b_sh_d = b_sh_q << PAIR_W;
        cnt_d  = cnt_q - CNT_W'(1);
        if (!dec_q && (p_gt || p_lt)) begin
          dec_d = 1'b1;
          gt_d  = p_gt;
          lt_d  = p_lt;
        end
        // Last pair folds into the published result on this edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          agtb_d  = gt_d;
          altb_d  = lt_d;
          aeqb_d  = !dec_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      agtb_q  <= 1'b0;
      aeqb_q  <= 1'b0;
      altb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      agtb_q  <= agtb_d;
      aeqb_q  <= aeqb_d;
      altb_q  <= altb_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.agtb = agtb_q;
  assign bus.aeqb = aeqb_q;
  assign bus.altb = altb_q;

endmodule

// File: tb/tb_serial_cmp.sv
// Directed bench for serial_cmp at WIDTH=8.
module tb_serial_cmp;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [2:0] prev;

  serial_cmp_if #(.WIDTH(8)) bus ();

  serial_cmp #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] res();
    return {bus.agtb, bus.aeqb, bus.altb};
  endfunction

  task automatic run_cmp(input string tag, input logic [7:0] ta,
                         input logic [7:0] tbv, input logic [2:0] exp,
                         input bit poke);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = ta;
    bus.b = tbv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~ta;
    bus.b = ~tbv;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 8'(bus.busy), 8'd1);
      chk({tag, "_nodone"}, 8'(bus.done), 8'd0);
      chk({tag, "_hold"}, 8'(res()), 8'(prev));
      if (poke && i == 1) begin
        bus.start = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'h00;
      end
      if (poke && i == 2) bus.start = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_done"}, 8'(bus.done), 8'd1);
    chk({tag, "_busy_off"}, 8'(bus.busy), 8'd0);
    chk({tag, "_res"}, 8'(res()), 8'(exp));
    prev = exp;
    @(negedge clk);
    chk({tag, "_done_off"}, 8'(bus.done), 8'd0);
    chk({tag, "_idle"}, 8'(bus.busy), 8'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    prev = 3'b000;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    #3;
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_res", 8'(res()), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_cmp("gt_5a_3c", 8'h5A, 8'h3C, 3'b100, 1'b0);
    run_cmp("eq_a5", 8'hA5, 8'hA5, 3'b010, 1'b0);
    run_cmp("lt_last", 8'h00, 8'h01, 3'b001, 1'b0);
`ifdef SERIAL_CMP_SIGNED_EN
    run_cmp("sign_80_7f", 8'h80, 8'h7F, 3'b001, 1'b0);
`else
    run_cmp("sign_80_7f", 8'h80, 8'h7F, 3'b100, 1'b0);
`endif
    run_cmp("run_poke", 8'h10, 8'h20, 3'b001, 1'b1);

    // start held: accepts at k, k+5, k+10
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h33;
    bus.b = 8'h33;
    @(negedge clk);
    chk("held_busy0", 8'(bus.busy), 8'd1);
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      chk("held_done", 8'(bus.done),
          8'((j == 4) || (j == 9) || (j == 14)));
      if (j == 4)  chk("held_eq", 8'(res()), 8'b010);
      if (j == 6)  chk("held_keep", 8'(res()), 8'b010);
      if (j == 9)  chk("held_lt", 8'(res()), 8'b001);
      if (j == 14) chk("held_gt", 8'(res()), 8'b100);
      if (j == 1) begin
        bus.a = 8'h01;
        bus.b = 8'h02;
      end
      if (j == 6) begin
        bus.a = 8'hF0;
        bus.b = 8'h0F;
      end
      if (j == 11) bus.start = 1'b0;
    end
    prev = 3'b100;

    // reset two cycles into a run
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h5A;
    bus.b = 8'h3C;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 8'(bus.busy), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 8'(bus.busy), 8'd0);
    chk("mid_rst_done", 8'(bus.done), 8'd0);
    chk("mid_rst_res", 8'(res()), 8'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_done", 8'(bus.done), 8'd0);
    rst_n = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'hC3;
    bus.b = 8'hC3;
    @(negedge clk);
    bus.start = 1'b0;
    prev = 3'b000;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_busy", 8'(bus.busy), 8'd1);
      chk("post_rst_nodone", 8'(bus.done), 8'd0);
      chk("post_rst_hold", 8'(res()), 8'(prev));
      @(negedge clk);
    end
    chk("post_rst_done", 8'(bus.done), 8'd1);
    chk("post_rst_eq", 8'(res()), 8'b010);
    prev = 3'b010;
    run_cmp("after_rst", 8'h00, 8'h01, 3'b001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_cmp.md
SERIAL_CMP -- requirements
Module: serial_cmp

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 2 (elaboration error otherwise).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to compare; sampled only in IDLE or DONE.
REQ-005 a  input  WIDTH  operand A; sampled on the start-accept edge only.
REQ-006 b  input  WIDTH  operand B; sampled on the start-accept edge only.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle pulse when results become valid.
REQ-009 agtb  output  1  registered result, A > B.
REQ-010 aeqb  output  1  registered result, A == B.
REQ-011 altb  output  1  registered result, A < B.

Function
REQ-012 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after WIDTH/2 RUN cycles; DONE->RUN on start, else DONE->IDLE.
REQ-013 Start accept: operands SHALL be captured into internal shift registers; pair counter SHALL load WIDTH/2; decided flag SHALL clear.
REQ-014 Each RUN cycle SHALL compare the top 2-bit pair of both shift registers, MSB pair first, then shift both left by 2 and decrement the counter.
REQ-015 The first pair that differs SHALL set decided and latch gt/lt; later pairs SHALL be ignored. No early exit: latency is fixed.
REQ-016 Latency: with start accepted at edge k, done SHALL be high for exactly the cycle after edge k+WIDTH/2; busy SHALL be high for the WIDTH/2 cycles before it.
REQ-017 On the DONE entry edge, agtb/aeqb/altb SHALL be updated; exactly one SHALL be high; aeqb high iff no pair differed.
REQ-018 Results SHALL hold until the next DONE entry; they SHALL NOT change during RUN.
REQ-019 start while in RUN SHALL be ignored (no restart, no operand capture).
REQ-020 start while in DONE SHALL be accepted: back-to-back compares with one DONE cycle between runs.
REQ-021 a/b changing outside the accept edge SHALL NOT affect the result.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, busy=0, done=0, agtb=0, aeqb=0, altb=0, counter and shift registers 0.
REQ-023 Reset mid-RUN SHALL abort the compare; no done pulse SHALL follow; after release the block SHALL accept start on the first edge.

Configuration
REQ-024 Macro SERIAL_CMP_SIGNED_EN: when defined, operands SHALL be compared as two's complement (bit WIDTH-1 of a and b inverted at capture); when undefined, operands SHALL be compared unsigned.

Structure
REQ-025 Package serial_cmp_pkg SHALL hold the FSM state typedef and the pair width constant (2).
REQ-026 One sub-module, cmp2_slice, SHALL perform the combinational 2-bit pair compare (outputs gt, lt); instantiated once.

Verification (WIDTH=8)
REQ-027 Reset release, start with a=8'h5A, b=8'h3C -> busy cycles 4, done pulse 4 cycles after accept, agtb=1, aeqb=0, altb=0.
REQ-028 a=8'hA5, b=8'hA5 -> aeqb=1; a=8'h00, b=8'h01 -> altb=1 (difference in last pair only).
REQ-029 a=8'h80, b=8'h7F -> unsigned build agtb=1; SERIAL_CMP_SIGNED_EN build altb=1.
REQ-030 start pulsed during RUN with different operands -> ignored, result matches first operands, single done pulse.
REQ-031 start held high continuously -> done every 5 cycles; results update per compare, held between.
REQ-032 rst_n low 2 cycles into RUN -> all outputs 0 immediately, no done pulse; new start after release completes normally.
